// File: rtl/score_board_if.sv
// -----------------------------------------------------------------------------
// score_board_if
// Bundles the game-state inputs and the score/display outputs of the match
// scoreboard so the block connects to the game controller and display through a
// single port.
//
// Signals
//   i_state        [1:0]  game state; 2'd2 = round over.
//   i_who_wins     [1:0]  round result: 0 none, 1 player 1, 2 player 2, 3 draw.
//   i_clear               one-cycle pulse that starts a new match.
//   o_p1_score     [3:0]  player 1 round wins.
//   o_p2_score     [3:0]  player 2 round wins.
//   o_match_over          high once a player has taken the match.
//   o_match_winner [1:0]  0 none, 1 player 1, 2 player 2.
//   o_hex0         [6:0]  player 1 digit, active-low, bit0=a .. bit6=g.
//   o_hex1         [6:0]  player 2 digit, same encoding.
//   o_led          [1:0]  bit0 = player 1 won, bit1 = player 2 won.
//
// Modports
//   master : the side that drives game state and reads the scoreboard.
//   slave  : the scoreboard itself.
// -----------------------------------------------------------------------------
interface score_board_if;
    logic [1:0] i_state;
    logic [1:0] i_who_wins;
    logic       i_clear;
    logic [3:0] o_p1_score;
    logic [3:0] o_p2_score;
    logic       o_match_over;
    logic [1:0] o_match_winner;
    logic [6:0] o_hex0;
    logic [6:0] o_hex1;
    logic [1:0] o_led;

    modport master (
        output i_state, i_who_wins, i_clear,
        input  o_p1_score, o_p2_score, o_match_over, o_match_winner,
        input  o_hex0, o_hex1, o_led
    );

    modport slave (
        input  i_state, i_who_wins, i_clear,
        output o_p1_score, o_p2_score, o_match_over, o_match_winner,
        output o_hex0, o_hex1, o_led
    );
endinterface

// File: rtl/score_board.sv
// -----------------------------------------------------------------------------
// score_board
// Best-of match scoreboard that sits downstream of the game-state controller.
// It detects the rising edge of the "round over" state, credits the round
// winner, and declares the match once a player reaches WIN_ROUNDS wins. Scores
// are shown on two seven-segment digits and the match result on two LEDs.
//
// Ports
//   clk   25 MHz game clock.
//   rst   synchronous, active-high reset.
//   bus   score_board_if.slave (game-state inputs, score/display outputs).
//
// Parameters
//   WIN_ROUNDS  round wins needed to take the match (1..9).
//   BLINK_DIV   clk cycles per blink half-period; only used with SCORE_BLINK_EN.
//
// Build option
//   SCORE_BLINK_EN  when defined, the winner's digit blinks after the match is
//                   decided; when undefined, all digits are steady.
// -----------------------------------------------------------------------------
module score_board #(
    parameter int WIN_ROUNDS = 3,
    parameter int BLINK_DIV  = 12500000
) (
    input  logic          clk,
    input  logic          rst,
    score_board_if.slave  bus
);

    // Reject configurations the single-digit display cannot show.
    if (WIN_ROUNDS < 1 || WIN_ROUNDS > 9) begin : g_bad_win_rounds
        $error("score_board: WIN_ROUNDS must be in 1..9");
    end
    if (BLINK_DIV < 1) begin : g_bad_blink_div
        $error("score_board: BLINK_DIV must be at least 1");
    end

    localparam logic [3:0] WIN_CNT    = 4'(WIN_ROUNDS);
    localparam logic [1:0] ST_OVER    = 2'd2;
    localparam logic [1:0] WHO_P1     = 2'd1;
    localparam logic [1:0] WHO_P2     = 2'd2;
    localparam logic [6:0] SEG_BLANK  = 7'h7F;

    typedef enum logic {
        S_PLAY,
        S_MATCH
    } state_t;

    // -------------------------------------------------------------------------
    // Active-low seven-segment decode; anything outside 0..9 shows blank.
    // -------------------------------------------------------------------------
    function automatic logic [6:0] seg7(input logic [3:0] digit);
        case (digit)
            4'd0:    seg7 = 7'h40;
            4'd1:    seg7 = 7'h79;
            4'd2:    seg7 = 7'h24;
            4'd3:    seg7 = 7'h30;
            4'd4:    seg7 = 7'h19;
            4'd5:    seg7 = 7'h12;
            4'd6:    seg7 = 7'h02;
            4'd7:    seg7 = 7'h78;
            4'd8:    seg7 = 7'h00;
            4'd9:    seg7 = 7'h10;
            default: seg7 = SEG_BLANK;
        endcase
    endfunction

    // -------------------------------------------------------------------------
    // Registered state and its next-state values
    // -------------------------------------------------------------------------
    state_t     state,      state_n;
    logic [3:0] p1_score,   p1_score_n;
    logic [3:0] p2_score,   p2_score_n;
    logic [1:0] winner,     winner_n;
    logic [1:0] prev_state;
    logic       round_end;

    // A round is counted once, on the cycle the controller enters "round over".
    // prev_state resets to the "over" code so a reset held while the game sits
    // in that state cannot produce a spurious round.
    assign round_end = (bus.i_state == ST_OVER) && (prev_state != ST_OVER);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_PLAY;
            prev_state <= ST_OVER;
            p1_score   <= '0;
            p2_score   <= '0;
            winner     <= '0;
        end else begin
            // NOTE: state registers use non-blocking assignment so every flop
            // samples the pre-edge values, independent of statement order.
            state      <= state_n;
            prev_state <= bus.i_state;
            p1_score   <= p1_score_n;
            p2_score   <= p2_score_n;
            winner     <= winner_n;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic. Clear has priority over a coincident round end, which
    // is simply dropped; prev_state still tracks i_state so that round is not
    // counted later either.
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every output of this block is given a default first, so no
        // path can leave a value unassigned and infer a latch.
        state_n    = state;
        p1_score_n = p1_score;
        p2_score_n = p2_score;
        winner_n   = winner;

        if (bus.i_clear) begin
            state_n    = S_PLAY;
            p1_score_n = '0;
            p2_score_n = '0;
            winner_n   = '0;
        end else begin
            case (state)
                S_PLAY: begin
                    if (round_end) begin
                        // Scores stay below WIN_CNT while playing, so the
                        // increment can never pass WIN_CNT or wrap.
                        if (bus.i_who_wins == WHO_P1) begin
                            p1_score_n = p1_score + 4'd1;
                            if (p1_score_n == WIN_CNT) begin
                                state_n  = S_MATCH;
                                winner_n = WHO_P1;
                            end
                        end else if (bus.i_who_wins == WHO_P2) begin
                            p2_score_n = p2_score + 4'd1;
                            if (p2_score_n == WIN_CNT) begin
                                state_n  = S_MATCH;
                                winner_n = WHO_P2;
                            end
                        end
                        // No winner or a draw leaves everything unchanged.
                    end
                end
                S_MATCH: begin
                    // Match decided: scores frozen until the next clear.
                end
                default: begin
                    state_n = S_PLAY;
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Winner-digit blink
    // -------------------------------------------------------------------------
    logic blink_off;

`ifdef SCORE_BLINK_EN
    logic [31:0] blink_cnt;
    logic        blink_phase;   // 1 = digit shown, 0 = digit blanked

    // Counter and phase are parked at (0, shown) outside S_MATCH, so the first
    // cycle of a decided match always starts a full "shown" half-period.
    always_ff @(posedge clk) begin
        if (rst || state != S_MATCH) begin
            blink_cnt   <= '0;
            blink_phase <= 1'b1;
        end else if (blink_cnt == 32'(BLINK_DIV - 1)) begin
            blink_cnt   <= '0;
            blink_phase <= ~blink_phase;
        end else begin
            blink_cnt   <= blink_cnt + 32'd1;
        end
    end

    assign blink_off = (state == S_MATCH) && !blink_phase;
`else
    assign blink_off = 1'b0;
`endif

    // -------------------------------------------------------------------------
    // Outputs: decodes of registered state only, so they move together with the
    // scores one cycle after the round end.
    // -------------------------------------------------------------------------
    assign bus.o_p1_score     = p1_score;
    assign bus.o_p2_score     = p2_score;
    assign bus.o_match_over   = (state == S_MATCH);
    assign bus.o_match_winner = winner;
    assign bus.o_led          = {winner == WHO_P2, winner == WHO_P1};
    assign bus.o_hex0         = (blink_off && winner == WHO_P1) ? SEG_BLANK
                                                                : seg7(p1_score);
    assign bus.o_hex1         = (blink_off && winner == WHO_P2) ? SEG_BLANK
                                                                : seg7(p2_score);

endmodule

// File: tb/tb_score_board.sv
// -----------------------------------------------------------------------------
// tb_score_board
// Directed scoreboard bench for score_board (WIN_ROUNDS=3, BLINK_DIV=4).
// Stimulus pushes the expected scoreboard outputs for a given cycle into a
// queue; a monitor on the falling edge pops and compares every entry that is
// due. Compile with +define+SCORE_BLINK_EN to expect the blinking winner digit.
// -----------------------------------------------------------------------------
module tb_score_board;

    localparam int WIN_ROUNDS = 3;
    localparam int BLINK_DIV  = 4;

    typedef struct {
        int         cyc;
        string      name;
        logic [3:0] p1;
        logic [3:0] p2;
        logic       over;
        logic [1:0] win;
        logic [6:0] hex0;
        logic [6:0] hex1;
        logic [1:0] led;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail  = 0;

    exp_t exp_q[$];

    // Last expected values, used for the "before the edge" latency checks.
    logic [3:0] cur_p1   = '0;
    logic [3:0] cur_p2   = '0;
    logic       cur_over = 1'b0;
    logic [1:0] cur_win  = '0;
    int         match_cyc = 0;

    score_board_if bus ();

    score_board #(
        .WIN_ROUNDS (WIN_ROUNDS),
        .BLINK_DIV  (BLINK_DIV)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #20 clk = ~clk;   // 25 MHz

    always @(posedge clk) cyc <= cyc + 1;

    // Hand-written active-low digit table.
    function automatic logic [6:0] seg(input logic [3:0] d);
        case (d)
            4'd0: seg = 7'h40;  4'd1: seg = 7'h79;  4'd2: seg = 7'h24;
            4'd3: seg = 7'h30;  4'd4: seg = 7'h19;  4'd5: seg = 7'h12;
            4'd6: seg = 7'h02;  4'd7: seg = 7'h78;  4'd8: seg = 7'h00;
            4'd9: seg = 7'h10;  default: seg = 7'h7F;
        endcase
    endfunction

    // Winner digit is blank during the second half of each 2*BLINK_DIV window
    // counted from the cycle the match was decided.
    function automatic logic winner_blank();
`ifdef SCORE_BLINK_EN
        return cur_over && (((cyc - match_cyc) / BLINK_DIV) % 2 == 1);
`else
        return 1'b0;
`endif
    endfunction

    task automatic check(input string nm, input int act, input int req);
        n_tests++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s @cycle %0d: got 0x%0h, expected 0x%0h", nm, cyc, act, req);
        end
    endtask

    // Queue the current expectation for this cycle's falling edge.
    task automatic expect_now(input string nm);
        exp_t e;
        e.cyc  = cyc;
        e.name = nm;
        e.p1   = cur_p1;
        e.p2   = cur_p2;
        e.over = cur_over;
        e.win  = cur_win;
        e.led  = {cur_win == 2'd2, cur_win == 2'd1};
        e.hex0 = (winner_blank() && cur_win == 2'd1) ? 7'h7F : seg(cur_p1);
        e.hex1 = (winner_blank() && cur_win == 2'd2) ? 7'h7F : seg(cur_p2);
        exp_q.push_back(e);
    endtask

    task automatic set_exp(input logic [3:0] p1, input logic [3:0] p2,
                           input logic over, input logic [1:0] win);
        if (over && !cur_over) match_cyc = cyc;
        cur_p1 = p1; cur_p2 = p2; cur_over = over; cur_win = win;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One round: leave "over", re-enter it with 'who', hold for 'hold' cycles.
    task automatic do_round(input string nm, input logic [1:0] who, input int hold,
                            input logic [3:0] p1, input logic [3:0] p2,
                            input logic over, input logic [1:0] win);
        bus.i_state = 2'd0;
        tick();
        bus.i_state    = 2'd2;
        bus.i_who_wins = who;
        expect_now({nm, "_pre"});        // not yet visible in the edge cycle
        tick();
        set_exp(p1, p2, over, win);
        expect_now({nm, "_post"});
        for (int i = 1; i < hold; i++) begin
            tick();
            expect_now({nm, "_hold"});   // holding at 2 must not recount
        end
        bus.i_state = 2'd0;
    endtask

    task automatic pulse_clear(input string nm);
        bus.i_clear = 1'b1;
        tick();
        bus.i_clear = 1'b0;
        set_exp(4'd0, 4'd0, 1'b0, 2'd0);
        expect_now(nm);
    endtask

    // Monitor: compare every queued expectation that has come due.
    always @(negedge clk) begin
        while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
            exp_t e;
            e = exp_q.pop_front();
            if (e.cyc < cyc) begin
                check({e.name, "_late"}, cyc, e.cyc);
            end else begin
                check({e.name, ".p1"},   int'(bus.o_p1_score),     int'(e.p1));
                check({e.name, ".p2"},   int'(bus.o_p2_score),     int'(e.p2));
                check({e.name, ".over"}, int'(bus.o_match_over),   int'(e.over));
                check({e.name, ".win"},  int'(bus.o_match_winner), int'(e.win));
                check({e.name, ".hex0"}, int'(bus.o_hex0),         int'(e.hex0));
                check({e.name, ".hex1"}, int'(bus.o_hex1),         int'(e.hex1));
                check({e.name, ".led"},  int'(bus.o_led),          int'(e.led));
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst            = 1'b1;
        bus.i_state    = 2'd2;
        bus.i_who_wins = 2'd1;
        bus.i_clear    = 1'b0;

        // Reset held with "round over" asserted: nothing counts.
        repeat (10) tick();
        expect_now("reset");
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            expect_now("after_reset_hold2");
        end

        // Player 1 builds a score through draws and no-result rounds.
        do_round("p1_r1",   2'd1, 5, 4'd1, 4'd0, 1'b0, 2'd0);
        do_round("draw",    2'd3, 3, 4'd1, 4'd0, 1'b0, 2'd0);
        do_round("none",    2'd0, 3, 4'd1, 4'd0, 1'b0, 2'd0);
        do_round("p1_r2",   2'd1, 5, 4'd2, 4'd0, 1'b0, 2'd0);
        do_round("p2_r1",   2'd2, 2, 4'd2, 4'd1, 1'b0, 2'd0);

        // Third win decides the match; follow the winner digit for 10 cycles.
        do_round("p1_win",  2'd1, 10, 4'd3, 4'd1, 1'b1, 2'd1);

        // Rounds after the match are ignored.
        do_round("frozen",  2'd2, 3, 4'd3, 4'd1, 1'b1, 2'd1);
        pulse_clear("clear_match");

        // Player 2 match, then a frozen player 1 round, then clear.
        do_round("p2_a",    2'd2, 2, 4'd0, 4'd1, 1'b0, 2'd0);
        do_round("p2_b",    2'd2, 2, 4'd0, 4'd2, 1'b0, 2'd0);
        do_round("p2_win",  2'd2, 2, 4'd0, 4'd3, 1'b1, 2'd2);
        do_round("p1_frz",  2'd1, 2, 4'd0, 4'd3, 1'b1, 2'd2);
        pulse_clear("clear_p2");

        // Clear in S_PLAY coinciding with a player 2 round end.
        do_round("p2_pre",  2'd2, 2, 4'd0, 4'd1, 1'b0, 2'd0);
        tick();
        bus.i_state    = 2'd2;
        bus.i_who_wins = 2'd2;
        pulse_clear("clear_vs_round");
        for (int i = 0; i < 3; i++) begin
            tick();
            expect_now("clear_vs_round_hold");
        end
        bus.i_state = 2'd0;

        // Reset in the middle of a match.
        do_round("mid_a",   2'd1, 1, 4'd1, 4'd0, 1'b0, 2'd0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        set_exp(4'd0, 4'd0, 1'b0, 2'd0);
        expect_now("mid_reset");
        do_round("post_rst", 2'd1, 2, 4'd1, 4'd0, 1'b0, 2'd0);

        // Drain the queue within a bounded number of cycles.
        for (int i = 0; i < 5 && exp_q.size() > 0; i++) tick();
        if (exp_q.size() > 0) check("queue_drain", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
